// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: parses [CMD][ADDR][LEN][DATA x LEN] SPI write frames into register-file writes.
// Latency: payload byte -> wr_valid one cycle after its rx_valid edge; retire pulse one cycle after the last handshake.
// Backpressure: wr_ready stalls the payload FIFO; a payload byte meeting a full, non-popping FIFO is dropped and errors the frame.
// Build option: define SPI_FRAME_CHECKSUM_EN to expect a trailing XOR checksum byte (CMD ^ ADDR ^ LEN ^ data).

// Small generic FIFO: head is visible combinationally, push into a full FIFO succeeds only alongside a pop.
module spi_frame_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full,
    output logic         one_left
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign one_left = (count == ONE_CNT);
    assign head_dat = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module spi_frame_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] CMD_WRITE  = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,       // asynchronous, active-low
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       ss,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_TAIL, S_ERR, S_DRAIN
    } state_t;

    state_t     state;
    state_t     byte_state;     // where this cycle's byte (if any) takes the FSM, before ss is considered
    logic       byte_err;
    logic       push;
    logic       pop;
    logic       trunc;
    logic       ss_q;
    logic       ss_fall;
    logic       ss_rise;
    logic       err_flag;
    logic [7:0] base;
    logic [7:0] len;
    logic [7:0] idx;
    logic [15:0] head;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_one;
`ifdef SPI_FRAME_CHECKSUM_EN
    logic [7:0] csum;
    logic       cs_seen;
    logic       cs_done;
`endif

    assign ss_fall  = ss_q & ~ss;
    assign ss_rise  = ~ss_q & ss;
    assign wr_valid = ~fifo_empty;
    assign pop      = wr_valid & wr_ready;
    assign wr_addr  = head[15:8];
    assign wr_data  = head[7:0];

    spi_frame_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat ({base + idx, rx_byte}),
        .pop      (pop),
        .head_dat (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .one_left (fifo_one)
    );

    // Decode the effect of the current byte on the frame parser.
    always_comb begin
        byte_state = state;
        byte_err   = 1'b0;
        push       = 1'b0;
        if (rx_valid) begin
            case (state)
                S_CMD: begin
                    if (rx_byte == CMD_WRITE) byte_state = S_ADDR;
                    else begin
                        byte_state = S_ERR;
                        byte_err   = 1'b1;
                    end
                end
                S_ADDR: byte_state = S_LEN;
                S_LEN:  byte_state = (rx_byte == 8'h00) ? S_TAIL : S_DATA;
                S_DATA: begin
                    if (fifo_full && !pop) begin
                        byte_state = S_ERR;
                        byte_err   = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (idx + 8'd1 == len) byte_state = S_TAIL;
                    end
                end
                S_TAIL: begin
`ifdef SPI_FRAME_CHECKSUM_EN
                    if (!cs_seen) byte_err = (rx_byte != csum);
                    else begin
                        byte_state = S_ERR;
                        byte_err   = 1'b1;
                    end
`else
                    byte_state = S_ERR;
                    byte_err   = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // A frame closed by ss before its expected bytes arrived is truncated.
`ifdef SPI_FRAME_CHECKSUM_EN
    assign cs_done = cs_seen | (rx_valid & (state == S_TAIL));
    assign trunc   = (byte_state inside {S_CMD, S_ADDR, S_LEN, S_DATA}) ||
                     ((byte_state == S_TAIL) && !cs_done);
`else
    assign trunc   = byte_state inside {S_CMD, S_ADDR, S_LEN, S_DATA};
`endif

    // Frame sequencer: state, frame context and the registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ss_q       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_flag   <= 1'b0;
            base       <= 8'h00;
            len        <= 8'h00;
            idx        <= 8'h00;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum       <= 8'h00;
            cs_seen    <= 1'b0;
`endif
        end else begin
            ss_q       <= ss;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ss_fall) begin
                        state    <= S_CMD;
                        busy     <= 1'b1;
                        err_flag <= 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
                        csum     <= 8'h00;
                        cs_seen  <= 1'b0;
`endif
                    end
                end
                S_DRAIN: begin
                    // Retire as the last queued write is accepted, so the pulse follows it by one cycle.
                    if (fifo_empty || (fifo_one && pop)) begin
                        frame_done <= ~err_flag;
                        frame_err  <= err_flag;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= byte_state;
                    if (byte_err) err_flag <= 1'b1;
                    if (rx_valid) begin
                        case (state)
                            S_ADDR: base <= rx_byte;
                            S_LEN: begin
                                len <= rx_byte;
                                idx <= 8'h00;
                            end
                            default: ;
                        endcase
                        if (push) idx <= idx + 8'd1;
`ifdef SPI_FRAME_CHECKSUM_EN
                        if (state inside {S_CMD, S_ADDR, S_LEN, S_DATA}) csum <= csum ^ rx_byte;
                        if (state == S_TAIL) cs_seen <= 1'b1;
`endif
                    end
                    // The byte of this cycle has been accounted for; ss closing the window wins the state.
                    if (ss_rise) begin
                        state <= S_DRAIN;
                        if (trunc) err_flag <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_ctrl.sv
`timescale 1ns/1ps
module tb_spi_frame_ctrl;
    localparam int         DEPTH = 4;
    localparam logic [7:0] CMD   = 8'hA5;
    typedef logic [7:0] bq_t [$];

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ss = 1'b1;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    always #5 clock = ~clock;

    spi_frame_ctrl #(.FIFO_DEPTH(DEPTH), .CMD_WRITE(CMD)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .ss         (ss),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int          ncmp = 0;
    int          nfail = 0;
    int          ndone = 0;
    int          nerr = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Observe accepted writes and retire pulses mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            if (wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
            if (frame_done) ndone++;
            if (frame_err) nerr++;
        end
    end

    // Sink readiness driver.
    initial begin
        forever begin
            @(posedge clock); #1;
            case (ready_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = 1'($urandom_range(0, 1));
                default: wr_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic bq_t with_cs(input bq_t b);
        bq_t r = b;
`ifdef SPI_FRAME_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (b[i]) x ^= b[i];
        r.push_back(x);
`endif
        return r;
    endfunction

    // Reference: whole-frame outcome from the byte list alone. cap = payload bytes the
    // sink can absorb before overflow (only meaningful when the sink is stalled throughout).
    task automatic model(input bq_t b, input int cap, output bit e);
        int n, avail, nw, extra;
        logic [7:0] base, a, x;
        exp_q.delete();
        e = 1'b0;
        if (b.size() < 1 || b[0] != CMD || b.size() < 3) begin
            e = 1'b1;
            return;
        end
        base  = b[1];
        n     = int'(b[2]);
        avail = b.size() - 3;
        nw    = (n < avail) ? n : avail;
        if (nw > cap) begin
            nw = cap;
            e  = 1'b1;
        end
        for (int i = 0; i < nw; i++) begin
            a = base + 8'(i);
            exp_q.push_back({a, b[3+i]});
        end
        if (e || avail < n) begin
            e = 1'b1;
            return;
        end
        extra = avail - n;
`ifdef SPI_FRAME_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < 3 + n; i++) x ^= b[i];
        if (extra == 0) e = 1'b1;
        else if (b[3+n] != x || extra > 1) e = 1'b1;
`else
        x = 8'h00;
        if (extra > 0) e = 1'b1;
`endif
    endtask

    task automatic send_bytes(input bq_t b, input bit rise_with_last);
        foreach (b[i]) begin
            rx_byte  = b[i];
            rx_valid = 1'b1;
            if (rise_with_last && i == b.size() - 1) ss = 1'b1;
            @(posedge clock); #1;
            rx_valid = 1'b0;
            rx_byte  = 8'($urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic run_frame(input string tag, input bq_t b, input bit rise_with_last,
                             input int rmode, input int cap);
        bit e;
        int d0, e0, g0, t, nexp;
        model(b, cap, e);
        d0 = ndone;
        e0 = nerr;
        g0 = got_q.size();
        ready_mode = rmode;
        @(posedge clock); #1;
        ss = 1'b0;
        @(posedge clock); #1;
        chk({tag, ":busy_rise"}, 32'(busy), 32'd1);
        send_bytes(b, rise_with_last);
        if (!rise_with_last || b.size() == 0) ss = 1'b1;
        @(posedge clock); #1;
        if (rmode == 2) begin
            repeat (4) @(posedge clock);
            #1;
            ready_mode = 0;
        end
        t = 0;
        while (ndone + nerr == d0 + e0 && t < 400) begin
            @(posedge clock); #1;
            t++;
        end
        chk({tag, ":retired"}, 32'(t < 400), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        chk({tag, ":done_cnt"}, 32'(ndone - d0), e ? 32'd0 : 32'd1);
        chk({tag, ":err_cnt"}, 32'(nerr - e0), e ? 32'd1 : 32'd0);
        chk({tag, ":busy_low"}, 32'(busy), 32'd0);
        chk({tag, ":fifo_empty"}, 32'(wr_valid), 32'd0);
        nexp = exp_q.size();
        chk({tag, ":n_writes"}, 32'(got_q.size() - g0), 32'(nexp));
        for (int i = 0; i < nexp && g0 + i < got_q.size(); i++)
            chk({tag, ":write"}, 32'(got_q[g0+i]), 32'(exp_q[i]));
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        bq_t b;
        bit  e;
        int  d0, e0;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Directed frames.
        run_frame("basic", with_cs('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33}), 1'b0, 0, 256);
        run_frame("wrap", with_cs('{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03}), 1'b0, 0, 256);
        run_frame("badcmd", '{8'h5A, 8'h10, 8'h02, 8'h11, 8'h22}, 1'b0, 0, 256);
        run_frame("overflow", with_cs('{8'hA5, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}),
                  1'b0, 2, DEPTH);
        run_frame("trunc", '{8'hA5, 8'h20, 8'h04, 8'hAA, 8'hBB}, 1'b0, 0, 256);
        run_frame("rise_last", with_cs('{8'hA5, 8'h30, 8'h02, 8'hC1, 8'hC2}), 1'b1, 1, 256);
        b = with_cs('{8'hA5, 8'h50, 8'h01, 8'h77});
        b.push_back(8'h99);
        run_frame("extra", b, 1'b0, 0, 256);
        run_frame("len0", with_cs('{8'hA5, 8'h60, 8'h00}), 1'b0, 0, 256);
`ifdef SPI_FRAME_CHECKSUM_EN
        run_frame("cs_good", with_cs('{8'hA5, 8'h00, 8'h01, 8'h7F}), 1'b0, 0, 256);
        b = with_cs('{8'hA5, 8'h00, 8'h01, 8'h7F});
        b[4] = b[4] ^ 8'h01;
        run_frame("cs_bad", b, 1'b0, 0, 256);
        run_frame("cs_missing", '{8'hA5, 8'h00, 8'h01, 8'h7F}, 1'b0, 0, 256);
`endif

        // Reset asserted mid-DATA with writes queued.
        ready_mode = 2;
        @(posedge clock); #1;
        ss = 1'b0;
        @(posedge clock); #1;
        send_bytes('{8'hA5, 8'h40, 8'h05, 8'h01, 8'h02}, 1'b0);
        chk("mid_wr_valid", 32'(wr_valid), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_head", 32'({wr_addr, wr_data}), 32'h4001);
        d0 = ndone;
        e0 = nerr;
        reset = 1'b0;
        #1;
        chk("arst_wr_valid", 32'(wr_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        ss = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        ready_mode = 0;
        repeat (5) @(posedge clock);
        #1;
        chk("arst_no_pulse", 32'((ndone - d0) + (nerr - e0)), 32'd0);
        chk("arst_idle", 32'({busy, wr_valid}), 32'd0);
        run_frame("post_rst", with_cs('{8'hA5, 8'h70, 8'h01, 8'h5C}), 1'b0, 0, 256);

        // Randomised frames with mutations; the model decides each outcome.
        for (int f = 0; f < 24; f++) begin
            int n, kind, rm, k;
            rm = $urandom_range(0, 1);
            n  = (rm == 1) ? $urandom_range(0, DEPTH) : $urandom_range(0, 8);
            b.delete();
            b.push_back(CMD);
            b.push_back(8'($urandom));
            b.push_back(8'(n));
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            b = with_cs(b);
            kind = $urandom_range(0, 5);
            case (kind)
                1: begin
                    b[0] = 8'($urandom);
                    if (b[0] == CMD) b[0] = 8'h5A;
                end
                2: begin
                    k = $urandom_range(0, b.size() - 1);
                    while (b.size() > k) void'(b.pop_back());
                end
                3: b.push_back(8'($urandom));
                4: b[b.size()-1] = b[b.size()-1] ^ 8'h5A;
                default: ;
            endcase
            run_frame("rnd", b, (kind == 5) || ($urandom_range(0, 3) == 0), rm, 256);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
